// File: rtl/y86_writeback_seq_if.sv
// Bus between a retiring Y86-64 instruction source and the write-back sequencer,
// including the register-file write port and status outputs the sequencer drives.
interface y86_writeback_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic        cnd;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic        done;
  logic        halted;
  logic        invalid;
  logic [31:0] retired;

  modport master (
    output in_valid, icode, cnd, rA, rB, valE, valM,
    input  in_ready, wr_en, wr_addr, wr_data, done, halted, invalid, retired
  );

  modport slave (
    input  in_valid, icode, cnd, rA, rB, valE, valM,
    output in_ready, wr_en, wr_addr, wr_data, done, halted, invalid, retired
  );
endinterface

// File: rtl/y86_writeback_seq.sv
// Y86-64 write-back sequencer: drives the register file's single write port,
// valE before valM, and tracks halt/invalid status and the retired count.
module y86_writeback_seq (
  input  logic                  clk,
  input  logic                  reset,
  y86_writeback_seq_if.slave    bus
);

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  typedef enum logic [1:0] {IDLE, WR_E, WR_M, DONE} state_t;

  state_t      state;
  logic [3:0]  icodeReg;
  logic [3:0]  dstMReg;
  logic [63:0] valMReg;
  logic        wrEn;
  logic [3:0]  wrAddr;
  logic [63:0] wrData;
  logic        doneReg;
  logic        haltedReg;
  logic        invalidReg;
  logic [31:0] retiredReg;
  logic        accept;
  logic [3:0]  acceptDstE;
  logic [3:0]  acceptDstM;

  assign bus.in_ready = (state == IDLE) && !haltedReg && !invalidReg;
  assign accept       = bus.in_valid && bus.in_ready;

  // Destinations of the instruction being presented, used only on the accept edge.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    acceptDstE = REG_NONE;
    acceptDstM = REG_NONE;
    unique case (bus.icode)
      4'h2:                      acceptDstE = bus.cnd ? bus.rB : REG_NONE;
      4'h3, 4'h6:                acceptDstE = bus.rB;
      4'h8, 4'h9, 4'hA, 4'hB:    acceptDstE = REG_RSP;
      default:                   acceptDstE = REG_NONE;
    endcase
    if (bus.icode == 4'h5 || bus.icode == 4'hB) acceptDstM = bus.rA;
  end

  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignment so every register sees pre-edge values.
    if (reset) begin
      state      <= IDLE;
      icodeReg   <= 4'h1;
      dstMReg    <= REG_NONE;
      valMReg    <= '0;
      wrEn       <= 1'b0;
      wrAddr     <= REG_NONE;
      wrData     <= '0;
      doneReg    <= 1'b0;
      haltedReg  <= 1'b0;
      invalidReg <= 1'b0;
      retiredReg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            icodeReg <= bus.icode;
            dstMReg  <= acceptDstM;
            valMReg  <= bus.valM;
            if (acceptDstE != REG_NONE) begin
              state  <= WR_E;
              wrEn   <= 1'b1;
              wrAddr <= acceptDstE;
              wrData <= bus.valE;
            end else if (acceptDstM != REG_NONE) begin
              state  <= WR_M;
              wrEn   <= 1'b1;
              wrAddr <= acceptDstM;
              wrData <= bus.valM;
            end else begin
              // Halt and invalid codes never write, so they always arrive here.
              state   <= DONE;
              doneReg <= 1'b1;
              if (bus.icode == 4'h0) haltedReg  <= 1'b1;
              if (bus.icode > 4'hB)  invalidReg <= 1'b1;
            end
          end
        end
        WR_E: begin
          if (dstMReg != REG_NONE) begin
            state  <= WR_M;
            wrAddr <= dstMReg;
            wrData <= valMReg;
          end else begin
            state   <= DONE;
            wrEn    <= 1'b0;
            wrAddr  <= REG_NONE;
            wrData  <= '0;
            doneReg <= 1'b1;
          end
        end
        WR_M: begin
          state   <= DONE;
          wrEn    <= 1'b0;
          wrAddr  <= REG_NONE;
          wrData  <= '0;
          doneReg <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          doneReg <= 1'b0;
          if (!(icodeReg > 4'hB)) retiredReg <= retiredReg + 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_en   = wrEn;
  assign bus.wr_addr = wrAddr;
  assign bus.wr_data = wrData;
  assign bus.done    = doneReg;
  assign bus.halted  = haltedReg;
  assign bus.invalid = invalidReg;
  assign bus.retired = retiredReg;

endmodule

// File: tb/tb_y86_writeback_seq.sv
// Directed bench for the Y86-64 write-back sequencer: per-cycle write-port
// traces and status flags against hand-computed expectations.
module tb_y86_writeback_seq;

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;

  y86_writeback_seq_if bus ();

  y86_writeback_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle trace: {wr_en, wr_addr, wr_data, done}.
  logic [69:0] capObs   [4];
  logic        capReady [4];

  function automatic logic [69:0] pk(input logic en, input logic [3:0] addr,
                                     input logic [63:0] data, input logic dn);
    return {en, addr, data, dn};
  endfunction

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      capObs[i]   = {bus.wr_en, bus.wr_addr, bus.wr_data, bus.done};
      capReady[i] = bus.in_ready;
    end
  endtask

  task automatic issue(input logic [3:0] ic, input logic c, input logic [3:0] a,
                       input logic [3:0] b, input logic [63:0] e, input logic [63:0] m);
    int waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 16) begin
      @(posedge clk); #1;
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      checkCount++;
      $display("FAIL issue_timeout in_ready=%b required 1", bus.in_ready);
    end
    bus.icode = ic; bus.cnd = c; bus.rA = a; bus.rB = b; bus.valE = e; bus.valM = m;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Scramble fields to show they are ignored after accept.
    bus.icode = 4'h6; bus.cnd = 1'b1; bus.rA = 4'h9; bus.rB = 4'hA;
    bus.valE = '1; bus.valM = 64'h0123_4567_89AB_CDEF;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.icode = 4'h1; bus.cnd = 1'b0; bus.rA = 4'hF; bus.rB = 4'hF;
    bus.valE = '0; bus.valM = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkCount++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.done} !== pk(1'b0, 4'hF, 64'd0, 1'b0))
      $display("FAIL reset_port got %h required %h", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.done},
               pk(1'b0, 4'hF, 64'd0, 1'b0));
    else passCount++;
    checkCount++;
    if ({bus.halted, bus.invalid, bus.retired, bus.in_ready} !== {1'b0, 1'b0, 32'd0, 1'b1})
      $display("FAIL reset_status got %h required %h", {bus.halted, bus.invalid, bus.retired, bus.in_ready},
               {1'b0, 1'b0, 32'd0, 1'b1});
    else passCount++;
  endtask

  // Issue one instruction, trace n cycles, compare trace, in_ready and retired.
  task automatic run_trace(input string name, input logic [3:0] ic, input logic c,
                           input logic [3:0] a, input logic [3:0] b,
                           input logic [63:0] e, input logic [63:0] m, input int n,
                           input logic [69:0] exp0, input logic [69:0] exp1,
                           input logic [69:0] exp2, input logic [69:0] exp3,
                           input logic [3:0] expReady, input logic [31:0] expRetired);
    logic [69:0] exp [4];
    exp = '{exp0, exp1, exp2, exp3};
    issue(ic, c, a, b, e, m);
    capture(n);
    for (int i = 0; i < n; i++) begin
      checkCount++;
      if (capObs[i] !== exp[i] || capReady[i] !== expReady[i])
        $display("FAIL %s cycle%0d got port=%h ready=%b required port=%h ready=%b",
                 name, i, capObs[i], capReady[i], exp[i], expReady[i]);
      else passCount++;
    end
    checkCount++;
    if (bus.retired !== expRetired)
      $display("FAIL %s_retired got %0d required %0d", name, bus.retired, expRetired);
    else passCount++;
  endtask

  localparam logic [69:0] IDLE_P = {1'b0, 4'hF, 64'd0, 1'b0};
  localparam logic [69:0] DONE_P = {1'b0, 4'hF, 64'd0, 1'b1};

  task automatic test_one_write();
    run_trace("irmovq", 4'h3, 1'b0, 4'hF, 4'h7, 64'h34_2486_7AEC, 64'h77, 3,
              pk(1'b1, 4'h7, 64'h34_2486_7AEC, 1'b0), DONE_P, IDLE_P, IDLE_P, 4'b0100, 32'd1);
    run_trace("pushq", 4'hA, 1'b0, 4'h2, 4'hF, 64'h1000, 64'h99, 3,
              pk(1'b1, 4'h4, 64'h1000, 1'b0), DONE_P, IDLE_P, IDLE_P, 4'b0100, 32'd2);
  endtask

  task automatic test_two_write();
    run_trace("popq_rsp", 4'hB, 1'b0, 4'h4, 4'hF, 64'h2008, 64'hDEAD, 4,
              pk(1'b1, 4'h4, 64'h2008, 1'b0), pk(1'b1, 4'h4, 64'hDEAD, 1'b0),
              DONE_P, IDLE_P, 4'b1000, 32'd3);
  endtask

  task automatic test_cmov();
    run_trace("cmov_cnd0", 4'h2, 1'b0, 4'h1, 4'h3, 64'h55, 64'h0, 2,
              DONE_P, IDLE_P, IDLE_P, IDLE_P, 4'b0010, 32'd4);
    run_trace("cmov_cnd1", 4'h2, 1'b1, 4'h1, 4'h3, 64'h55, 64'h0, 3,
              pk(1'b1, 4'h3, 64'h55, 1'b0), DONE_P, IDLE_P, IDLE_P, 4'b0100, 32'd5);
  endtask

  task automatic test_halt();
    run_trace("mrmovq", 4'h5, 1'b0, 4'h5, 4'h1, 64'h40, 64'hBEEF, 3,
              pk(1'b1, 4'h5, 64'hBEEF, 1'b0), DONE_P, IDLE_P, IDLE_P, 4'b0100, 32'd6);
    run_trace("halt", 4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0, 2,
              DONE_P, IDLE_P, IDLE_P, IDLE_P, 4'b0000, 32'd7);
    checkCount++;
    if (bus.halted !== 1'b1) $display("FAIL halted_set got %b required 1", bus.halted);
    else passCount++;
    // A nop presented after halt must never be taken.
    bus.icode = 4'h1; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkCount++;
      if ({bus.wr_en, bus.done, bus.in_ready, bus.retired} !== {3'b000, 32'd7})
        $display("FAIL nop_after_halt cycle%0d got %h required %h", i,
                 {bus.wr_en, bus.done, bus.in_ready, bus.retired}, {3'b000, 32'd7});
      else passCount++;
    end
    bus.in_valid = 1'b0;
    do_reset();
    checkCount++;
    if ({bus.halted, bus.in_ready, bus.retired} !== {1'b0, 1'b1, 32'd0})
      $display("FAIL halt_reset got %h required %h", {bus.halted, bus.in_ready, bus.retired},
               {1'b0, 1'b1, 32'd0});
    else passCount++;
  endtask

  task automatic test_invalid();
    run_trace("invalid_c", 4'hC, 1'b0, 4'h2, 4'h3, 64'h11, 64'h22, 2,
              DONE_P, IDLE_P, IDLE_P, IDLE_P, 4'b0000, 32'd0);
    checkCount++;
    if (bus.invalid !== 1'b1) $display("FAIL invalid_set got %b required 1", bus.invalid);
    else passCount++;
    do_reset();
  endtask

  task automatic test_reset_mid();
    issue(4'hB, 1'b0, 4'h4, 4'hF, 64'h3000, 64'hCAFE);
    @(negedge clk);
    checkCount++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 4'h4, 64'h3000})
      $display("FAIL mid_wr_e got %h required %h", {bus.wr_en, bus.wr_addr, bus.wr_data},
               {1'b1, 4'h4, 64'h3000});
    else passCount++;
    reset = 1'b1;
    @(negedge clk);
    checkCount++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.done, bus.halted, bus.invalid, bus.retired, bus.in_ready}
        !== {IDLE_P, 1'b0, 1'b0, 32'd0, 1'b1})
      $display("FAIL mid_reset got %h required %h",
               {bus.wr_en, bus.wr_addr, bus.wr_data, bus.done, bus.halted, bus.invalid, bus.retired, bus.in_ready},
               {IDLE_P, 1'b0, 1'b0, 32'd0, 1'b1});
    else passCount++;
    reset = 1'b0;
    capture(2);
    checkCount++;
    if (capObs[0] !== IDLE_P || capObs[1] !== IDLE_P || capReady[1] !== 1'b1)
      $display("FAIL mid_after got %h/%h ready=%b required %h ready=1", capObs[0], capObs[1],
               capReady[1], IDLE_P);
    else passCount++;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    test_reset();
    test_one_write();
    test_two_write();
    test_cmov();
    test_halt();
    test_invalid();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/y86_writeback_seq.md
# y86_writeback_seq

Write-back sequencer for the Y86-64 sequential datapath: the writing end of the register-file interface. Accepts one retiring instruction per handshake (icode, cnd, rA, rB, valE, valM) and computes the destinations dstE/dstM. It drives the register file's single write port over one or two cycles, always ordering the valE write before the valM write. It also tracks the halted/invalid processor status and counts retired instructions.

## Interface
- No parameters; data width fixed at 64, register IDs 4 bits, 4'hF = no register, 4'h4 = %rsp.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; one clock, synchronous active-high reset (fixed).
- in_valid  input  1  retiring instruction presented.
- in_ready  output  1  sequencer can accept; high only in IDLE with no halt or error.
- icode  input  4  instruction code.
- cnd  input  1  condition flag from execute.
- rA, rB  input  4  register specifiers.
- valE, valM  input  64  ALU result, memory read data.
- wr_en  output  1  register-file write strobe.
- wr_addr  output  4  write register ID.
- wr_data  output  64  write data.
- done  output  1  one-cycle pulse when an accepted instruction finishes.
- halted  output  1  sticky; set by icode 0.
- invalid  output  1  sticky; set by icode > 4'hB.
- retired  output  32  count of completed instructions.

## Operation
- Handshake: accept when in_valid && in_ready at a rising edge. Latch icode, rA, rB, valE and valM; compute dstE and dstM from the latched fields.
- dstE:
  - icode 2 (rrmovq/cmovXX): rB if cnd, else F.
  - icode 3 and 6: rB.
  - icode 8, 9, A, B: 4.
  - Otherwise: F.
- dstM:
  - icode 5 and B: rA.
  - Otherwise: F.
- States: IDLE, WR_E, WR_M, DONE.
- IDLE to WR_E on accept when dstE != F.
- IDLE to WR_M on accept when dstE == F and dstM != F.
- IDLE to DONE on accept when both are F. Covers nop, halt, rmmovq, jXX, and a cmov with cnd=0.
- WR_E: wr_en=1, wr_addr=dstE, wr_data=valE. Next state is WR_M if dstM != F, else DONE.
- WR_M: wr_en=1, wr_addr=dstM, wr_data=valM. Next state is DONE.
- DONE: done=1. retired increments on the edge leaving DONE, wrapping at 2^32. Next state is IDLE.
- icode 0: no writes. Reaching DONE sets halted. in_ready stays low until reset.
- icode > B: no writes; goes straight to DONE. Sets invalid; retired does not increment. in_ready stays low until reset.
- popq %rsp (rA=4): dstE=dstM=4. valE is written first, then valM, so the register-file final value is valM.
- Outputs are decoded from state and latched fields only, never directly from inputs. When wr_en=0, wr_addr=4'hF and wr_data=0.
- Inputs changing while not in IDLE are ignored.

## Timing
- Reset values:
  - state = IDLE.
  - wr_en=0, wr_addr=F, wr_data=0.
  - done=0, halted=0, invalid=0, retired=0.
  - in_ready=1 from the cycle after reset deasserts.
- Accept at edge t0.
- Two-write instruction:
  - WR_E occupies cycle t0..t1; the register file commits at t1.
  - WR_M occupies t1..t2; commits at t2.
  - DONE occupies t2..t3; in_ready returns at t3.
- One-write instruction: DONE occupies t1..t2; in_ready returns at t2.
- Zero-write instruction: DONE occupies t0..t1.
- Throughput: one instruction per 2–4 cycles. No back-to-back accept; in_ready is low from accept until IDLE is re-entered.
- Reset asserted mid-sequence: abandon at the next edge, with no further writes. A write already strobed in the current cycle still commits at that edge. All outputs return to reset values.
- reset has priority over accept on the same edge.

## Test plan
- irmovq, rB=7, valE=0x3424867AEC: exactly one write (addr 7, data 0x3424867AEC) in the cycle after accept. done follows one cycle later; retired=1.
- pushq, rA=2, rB=F, valE=0x1000: one write (addr 4, data 0x1000); no valM write.
- popq, rA=4, valE=0x2008, valM=0xDEAD:
  - cycle 1 writes (4, 0x2008);
  - cycle 2 writes (4, 0xDEAD);
  - done in cycle 3.
- cmovXX, cnd=0, rB=3: no wr_en at all. done in the cycle after accept; retired increments. Repeat with cnd=1: write (3, valE).
- mrmovq rA=5 then halt then nop:
  - mrmovq writes (5, valM);
  - halt sets halted and drops in_ready;
  - nop is never accepted;
  - reset clears halted.
- icode=C: invalid=1, no writes, retired unchanged. Assert reset during WR_E of a popq: no WR_M write, and all outputs are at reset values.
